// File: rtl/cla_wide_add_sequencer_pkg.sv
// Shared types for the wide-add sequencer.
// Holds the state enum and its width.
package cla_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_wide_add_sequencer_adder.sv
// WIDTH-bit carry-lookahead adder slice.
// Ports: A, B, Cin in; S, Cout out. Purely combinational.
module Carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    S    = p ^ c[WIDTH-1:0];
    Cout = c[WIDTH];
  end

endmodule

// File: rtl/cla_wide_add_sequencer.sv
// WORDS x WIDTH adder built from one shared CLA slice, LSW first.
// Ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_cin requester side,
// out_valid/out_ready/out_sum/out_cout consumer side, busy.
// CLA_SEQ_SUB_EN adds in_sub: B inverted, carry forced to 1 (A-B).
module cla_wide_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   in_sub,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int W     = WIDTH * WORDS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] s_w;
  logic             co_w;
  int               off;
  logic             cin0;

`ifdef CLA_SEQ_SUB_EN
  logic sub_q;
`endif

  always_comb begin
    off = int'(idx) * WIDTH;
    a_w = op_a[off +: WIDTH];
`ifdef CLA_SEQ_SUB_EN
    b_w  = op_b[off +: WIDTH] ^ {WIDTH{sub_q}};
    cin0 = in_sub | in_cin;
`else
    b_w  = op_b[off +: WIDTH];
    cin0 = in_cin;
`endif
  end

  Carry_lookahead_adder #(
    .WIDTH(WIDTH)
  ) u_cla (
    .A   (a_w),
    .B   (b_w),
    .Cin (carry),
    .S   (s_w),
    .Cout(co_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            carry    <= cin0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef CLA_SEQ_SUB_EN
            sub_q    <= in_sub;
`endif
          end
        end
        RUN: begin
          out_sum[off +: WIDTH] <= s_w;
          carry <= co_w;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            out_cout  <= co_w;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_wide_add_sequencer.sv
// Bench for cla_wide_add_sequencer: vector table, directed corners,
// random ops against a plain-arithmetic 65-bit reference.
module tb_cla_wide_add_sequencer;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int W     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef CLA_SEQ_SUB_EN
  logic         in_sub = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  cla_wide_add_sequencer #(
    .WIDTH(WIDTH),
    .WORDS(WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef CLA_SEQ_SUB_EN
    .in_sub   (in_sub),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation. hold < 0 picks a random backpressure length.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] es, input logic ec,
                        input bit rnd, input int hold);
    int n;
    int h;
    logic [W-1:0] snap;
    if (rnd) repeat ($urandom_range(0, 3)) tick();
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract requested without CLA_SEQ_SUB_EN");
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(n), 128'(0));
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (rnd) begin
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_cin = 1'($urandom);
    end
    chk("busy_run", 128'(busy), 128'(1));
    n = 0;
    while (!out_valid && n < 50) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("in_ready_run", 128'(in_ready), 128'(0));
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("latency", 128'(n), 128'(WORDS));
    if (!out_valid) return;
    chk("sum", 128'(out_sum), 128'(es));
    chk("cout", 128'(out_cout), 128'(ec));
    snap = out_sum;
    h = (hold < 0) ? $urandom_range(0, 3) : hold;
    repeat (h) begin
      tick();
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_sum", 128'(out_sum), 128'(snap));
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_done++;
    chk("valid_drop", 128'(out_valid), 128'(0));
    chk("in_ready_back", 128'(in_ready), 128'(1));
    chk("busy_idle", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   ref_sum;

    tbl[0] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0001_0000_0000_0000, 1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    tbl[2] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
               64'h0, 1'b1};
    tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
               64'h2222_2222_2222_2212, 1'b0};

    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sum", 128'(out_sum), 128'(0));
    chk("rst_cout", 128'(out_cout), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0,
             tbl[i].sum, tbl[i].cout, 1'b0, 0);
    end

    // backpressure: ten cycles of out_ready low
    run_op(64'h0000_0000_0001_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0002_0000, 1'b0, 1'b0, 10);

    // reset in RUN after words 0 and 1 have been written
    in_a     = 64'h1111_2222_3333_4444;
    in_b     = 64'h1111_1111_1111_1111;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_sum", 128'(out_sum), 128'(0));
    chk("mid_rst_cout", 128'(out_cout), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
           64'h2222_3333_4444_5555, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 0);
    in_sub = 1'b0;
`endif

    n_done = 0;
    for (int k = 0; k < 1000; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (k % 10 == 0) ra = '1;
      ref_sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, 1'b0, ref_sum[W-1:0], ref_sum[W],
             1'b1, -1);
    end
    chk("ops_completed", 128'(n_done), 128'(1000));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
